// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and helpers for the MEM-stage data memory
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t RESP = 2'd2;
  localparam logic [31:0] RDATA_NONE = 32'h0;
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    return sz == SZ_BYTE ? 3'd1 : sz == SZ_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: sign/zero extension of little-endian load data
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  always_comb
    data = size == SZ_BYTE ? {{24{~uns & raw[7]}}, raw[7:0]} :
           size == SZ_HALF ? {{16{~uns & raw[15]}}, raw[15:0]} :
           size == SZ_WORD ? raw : RDATA_NONE;
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressable data memory with req/rsp handshake and wait states
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  logic [7:0] mem [DEPTH];
  state_t state;
  logic [3:0] cnt;
  logic rdy_q, we_q, uns_q;
  logic [1:0] size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q;
  logic accept, go, we_s, uns_s, err;
  logic [1:0] size_s;
  logic [ADDR_W-1:0] a;
  logic [ADDR_W:0] last;
  logic [2:0] nb;
  logic [31:0] wdata_s, raw, ext;
  assign req_ready = rdy_q && state == IDLE;
  assign rsp_valid = state == RESP;
  assign accept = req_valid && req_ready;
  // Zero-wait accesses use the live request; delayed ones use the latched copy.
  always_comb begin
    we_s = state == IDLE ? req_we : we_q;
    uns_s = state == IDLE ? req_unsigned : uns_q;
    size_s = state == IDLE ? req_size : size_q;
    a = state == IDLE ? req_addr : addr_q;
    wdata_s = state == IDLE ? req_wdata : wdata_q;
    nb = size_bytes(size_s);
    last = {1'b0, a} + (ADDR_W+1)'(nb);
    err = size_s == SZ_RSVD || (size_s == SZ_HALF && a[0]) ||
          (size_s == SZ_WORD && a[1:0] != 2'b00) || last > (ADDR_W+1)'(DEPTH);
    raw = {mem[a + ADDR_W'(3)], mem[a + ADDR_W'(2)], mem[a + ADDR_W'(1)], mem[a]};
    go = WAIT_CYCLES == 0 ? accept : (state == WAIT && cnt == 4'd0);
  end
  dmem_load_ext u_ext (.raw(raw), .size(size_s), .uns(uns_s), .data(ext));
  always_ff @(posedge clk)
    if (rst_n && go && we_s && !err)
      for (int k = 0; k < 4; k++)
        if (k < int'(nb)) mem[a + ADDR_W'(k)] <= wdata_s[8*k +: 8];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      rdy_q <= 1'b0;
      rsp_rdata <= RDATA_NONE;
      rsp_err <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (state == IDLE && accept) begin
        we_q <= req_we;
        uns_q <= req_unsigned;
        size_q <= req_size;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        state <= WAIT_CYCLES == 0 ? RESP : WAIT;
        cnt <= 4'(WAIT_CYCLES - 1);
      end else if (state == WAIT) begin
        state <= cnt == 4'd0 ? RESP : WAIT;
        cnt <= cnt - 4'd1;
      end else if (state == RESP) state <= IDLE;
      if (go) begin
        rsp_rdata <= (err || we_s) ? RDATA_NONE : ext;
        rsp_err <= err;
      end
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed checks for zero-wait and three-wait instances
module tb_dmem_ctrl;
  logic clk, rst_n;
  logic req_valid [2], req_ready [2], req_we [2], req_unsigned [2];
  logic [1:0] req_size [2];
  logic [7:0] req_addr [2];
  logic [31:0] req_wdata [2], rsp_rdata [2];
  logic rsp_valid [2], rsp_err [2];
  int checks = 0, failures = 0;
  dmem_ctrl #(.ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
  dmem_ctrl #(.ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input int d, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [7:0] a, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz;
    req_unsigned[d] = uns; req_addr[d] = a; req_wdata[d] = wd;
  endtask
  task automatic xfer(input int d, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [7:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    drive(d, we, sz, uns, a, wd);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_addr[d] = 8'hEE;
    lat = 1;
    while (!rsp_valid[d] && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata[d];
    er = rsp_err[d];
  endtask
  task automatic op(input string tag, input int d, input logic we, input logic [1:0] sz,
                    input logic uns, input logic [7:0] a, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic er;
    int lat;
    xfer(d, we, sz, uns, a, wd, rd, er, lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(er), 32'(exp_er));
    chk({tag, "_lat"}, 32'(lat), d == 0 ? 32'd1 : 32'd4);
  endtask
  initial begin
    int pulses, plat, first, second;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_we[d] = 0; req_size[d] = 0;
      req_unsigned[d] = 0; req_addr[d] = 0; req_wdata[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", 32'(req_ready[0]), 32'd0);
    chk("rst_ready3", 32'(req_ready[1]), 32'd0);
    chk("rst_valid0", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rdata0", rsp_rdata[0], 32'd0);
    chk("rst_err0", 32'(rsp_err[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready0", 32'(req_ready[0]), 32'd1);
    chk("rel_ready3", 32'(req_ready[1]), 32'd1);
    op("sw10", 0, 1, 2'b10, 0, 8'h10, 32'h8765_4321, 32'h0, 0);
    op("lw10", 0, 0, 2'b10, 0, 8'h10, 32'h0, 32'h8765_4321, 0);
    op("lw10u", 0, 0, 2'b10, 1, 8'h10, 32'h0, 32'h8765_4321, 0);
    op("lb13", 0, 0, 2'b00, 0, 8'h13, 32'h0, 32'hFFFF_FF87, 0);
    op("lbu13", 0, 0, 2'b00, 1, 8'h13, 32'h0, 32'h0000_0087, 0);
    op("lb10", 0, 0, 2'b00, 0, 8'h10, 32'h0, 32'h0000_0021, 0);
    op("lh12", 0, 0, 2'b01, 0, 8'h12, 32'h0, 32'hFFFF_8765, 0);
    op("lhu10", 0, 0, 2'b01, 1, 8'h10, 32'h0, 32'h0000_4321, 0);
    op("sh11", 0, 1, 2'b01, 0, 8'h11, 32'h0000_BEEF, 32'h0, 1);
    op("lw10b", 0, 0, 2'b10, 0, 8'h10, 32'h0, 32'h8765_4321, 0);
    op("sw12", 0, 1, 2'b10, 0, 8'h12, 32'h5555_5555, 32'h0, 1);
    op("swFD", 0, 1, 2'b10, 0, 8'hFD, 32'h1234_5678, 32'h0, 1);
    op("rsvd", 0, 0, 2'b11, 0, 8'h10, 32'h0, 32'h0, 1);
    op("lw10c", 0, 0, 2'b10, 0, 8'h10, 32'h0, 32'h8765_4321, 0);
    op("swFC", 0, 1, 2'b10, 0, 8'hFC, 32'hCAFE_F00D, 32'h0, 0);
    op("lwFC", 0, 0, 2'b10, 0, 8'hFC, 32'h0, 32'hCAFE_F00D, 0);
    op("lbuFF", 0, 0, 2'b00, 1, 8'hFF, 32'h0, 32'h0000_00CA, 0);
    op("lhFE", 0, 0, 2'b01, 0, 8'hFE, 32'h0, 32'hFFFF_CAFE, 0);
    op("lhFF", 0, 0, 2'b01, 0, 8'hFF, 32'h0, 32'h0, 1);
    drive(1, 1, 2'b10, 0, 8'h40, 32'h1234_5678);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    pulses = 0; plat = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i <= 4) chk("w3_busy", 32'(req_ready[1]), 32'd0);
      if (i == 2) begin req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 8'h44; end
      if (i == 3) req_valid[1] = 1'b0;
      if (rsp_valid[1]) begin pulses++; plat = i; end
      if (i == 5) chk("w3_idle", 32'(req_ready[1]), 32'd1);
      @(posedge clk); #1;
    end
    chk("w3_pulses", 32'(pulses), 32'd1);
    chk("w3_plat", 32'(plat), 32'd4);
    op("w3_lw40", 1, 0, 2'b10, 0, 8'h40, 32'h0, 32'h1234_5678, 0);
    op("w3_lbu42", 1, 0, 2'b00, 1, 8'h42, 32'h0, 32'h0000_0034, 0);
    op("w3_sw20z", 1, 1, 2'b10, 0, 8'h20, 32'h0, 32'h0, 0);
    drive(1, 1, 2'b10, 0, 8'h20, 32'h1111_1111);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (rsp_valid[1]) pulses++; end
    chk("abort_pulses", 32'(pulses), 32'd0);
    chk("abort_ready", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op("abort_lw20", 1, 0, 2'b10, 0, 8'h20, 32'h0, 32'h0, 0);
    drive(1, 1, 2'b10, 0, 8'h20, 32'h2222_2222);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (rsp_valid[1]) pulses++; end
    chk("edge_pulses", 32'(pulses), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op("edge_lw20", 1, 0, 2'b10, 0, 8'h20, 32'h0, 32'h0, 0);
    op("sw30", 0, 1, 2'b10, 0, 8'h30, 32'h0, 32'h0, 0);
    op("sb31", 0, 1, 2'b00, 0, 8'h31, 32'h1234_56AA, 32'h0, 0);
    op("lw30", 0, 0, 2'b10, 0, 8'h30, 32'h0, 32'h0000_AA00, 0);
    for (int d = 0; d < 2; d++) begin
      drive(d, 0, 2'b10, 0, 8'h30, 32'h0);
      first = -1; second = -1;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (rsp_valid[d]) begin
          if (first < 0) first = i;
          else if (second < 0) second = i;
        end
      end
      req_valid[d] = 1'b0;
      chk(d == 0 ? "b2b_w0" : "b2b_w3", 32'(second - first), d == 0 ? 32'd2 : 32'd5);
    end
    repeat (8) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
